core_param: RTL
===============

Name: core_param

Overview:
- Parametrised next-generation execution core for the multi-core array. Configurable data width, register count and interrupt-vector count.
- Executes one fixed-format 32-bit instruction per fetch, with condition suffixes, flag-producing ALU ops and blocking load/store over the request/response memory handshake.
- Behaviour the previous core lacked: synchronous reset, vectored interrupt entry, relative jumps and a core-index read.

Parameters:
- WIDTH, 32, data/register/address width (≥16).
- REG_NUM, 8, number of general registers r0..r(REG_NUM-1), 2..16; r(REG_NUM-1) is sp by convention.
- CORE_NUM, 2, width of core_index.
- INT_NUM, 3, width of int_num and int_vector.
- VEC_BASE, 0, ip loaded on interrupt entry for vector 0.
- VEC_STRIDE, 16, ip spacing between vectors.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- instruction  in  32  instruction word at instr_addr, valid the cycle after instr_addr is stable.
- instr_addr  out  WIDTH  equals ip.
- core_index  in  CORE_NUM  static core id.
- request  out  1  memory access pending.
- wren  out  1  1 = store, 0 = load; valid while request=1.
- address  out  WIDTH  memory address; valid while request=1.
- writedata  out  WIDTH  store data; valid while request=1.
- readdata  in  WIDTH  load data; sampled when response=1.
- response  in  1  memory access complete.
- interrupt_start  in  1  start execution.
- int_vector  in  INT_NUM  entry vector; sampled with interrupt_start.
- interrupt_finish  out  1  one-cycle pulse on halt.
- int_num  out  INT_NUM  halt code; held until next halt.

Behaviour:
- Encoding (fixed):
  - [31:30] class: 00 ALU, 01 MOV, 10 MEM, 11 CTRL.
  - [29:27] cond: 000 always, 001 Z, 010 !Z, 011 C, 100 S!=O, 101 S==O, 11x never.
  - [26:24] sub; [23:20] rd; [19:16] rs; [15:0] imm.
- Flags register {Z,O,S,C}, bits [3:0] = C,S,O,Z.
- Reset: all registers, ip, flags, request, wren, address, writedata, interrupt_finish and int_num go to 0; state goes to IDLE. Reset mid-memory-access abandons the access: request=0 next cycle. Reset wins over interrupt_start in the same cycle.
- States: IDLE, FETCH, EXEC, MEM_WAIT.
  - IDLE: on interrupt_start, ip <= VEC_BASE + int_vector*VEC_STRIDE (mod 2^WIDTH), then go to FETCH. interrupt_start in any other state is ignored (not queued).
  - FETCH: one cycle; instruction is latched into an internal instruction register at its end; then go to EXEC.
  - EXEC: evaluate cond.
    - Cond false: only ip <= ip+1, then FETCH. No register, flag or memory effect.
    - Cond true: perform the operation and go to FETCH (or MEM_WAIT for MEM).
    - Non-memory instruction: 2 cycles total.
- ALU sub:
  - 000 add; 001 sub; 010 and; 011 or; 100 xor.
  - 101 shl, 110 shr: logical, by rs value; amount ≥ WIDTH gives 0.
  - 111 cmp: sub with no writeback.
  - Operation is rd <= rd op rs, modulo 2^WIDTH.
  - Flags update only on executed ALU ops:
    - Z = result==0; S = result msb.
    - add: C = carry out; O = signed overflow.
    - sub/cmp: C = unsigned borrow (rd<rs); O = signed overflow.
    - logic/shift: C = 0, O = 0.
- MOV sub:
  - 000 rd <= rs.
  - 001 rd[15:0] <= imm, upper bits kept.
  - 010 rd[WIDTH-1:WIDTH-16] <= imm, lower bits kept.
  - 011 rd <= zero-extended flags.
  - 100 rd <= zero-extended core_index.
  - Others: no-op.
- MEM sub:
  - 000 load rd <= mem[rs]; 001 store mem[rs] <= rd.
  - EXEC registers request=1, wren, address=rs, writedata=rd, then goes to MEM_WAIT. Outputs hold stable until response=1.
  - On the response cycle, load writes rd from readdata; request=0 the next cycle; ip <= ip+1; go to FETCH.
  - response while request=0 is ignored. Response in the same cycle request rises is not possible (request is registered).
- CTRL sub:
  - 000 ip <= rs.
  - 001 ip <= ip + sign-extended imm, relative to the current instruction.
  - 111 halt: int_num <= imm[INT_NUM-1:0]; interrupt_finish=1 for exactly one cycle; ip unchanged; go to IDLE.
  - Others: no-op.
- Register index ≥ REG_NUM: reads return 0, writes are dropped.
- ip wraps modulo 2^WIDTH.

Test Plan:
- Reset, then interrupt_start with int_vector=2 (VEC_BASE=0, STRIDE=16) -> instr_addr=32 in FETCH; halt imm=5 -> interrupt_finish high exactly 1 cycle, int_num=5, state IDLE.
- movl r1,0xFFFF; movh r1,0xFFFF; movl r2,1; add r1,r2 -> r1=0, flags C=1, Z=1, S=0, O=0; movf r3 -> r3=0x9.
- movl r1,3; movl r2,5; cmp r1,r2; then jmprel imm=-2 with cond 100 (lt) -> branch taken, ip = jump address-2; cond 101 (ge) -> not taken, ip+1, r1 unchanged at 3.
- Store r4=0xDEADBEEF to address r5=0x100, response delayed 3 cycles -> request, wren=1, address=0x100 and writedata held stable for 3 cycles, request drops the cycle after response; load back to r6 with readdata=0xDEADBEEF -> r6=0xDEADBEEF.
- Assert reset during MEM_WAIT -> request=0 and state IDLE the next cycle, registers 0; interrupt_start pulsed while in EXEC -> ignored, no ip change.
- REG_NUM=4 build: mov r9,r1 dropped; mov r1,r9 -> r1=0; movci r0 with core_index=2 -> r0=2.

Source files
------------

// File: rtl/core_param.sv
// core_param: parametrised execution core.
// Fetch/exec/mem-wait sequencer with vectored interrupt entry.
module core_param #(
  parameter int WIDTH      = 32,
  parameter int REG_NUM    = 8,
  parameter int CORE_NUM   = 2,
  parameter int INT_NUM    = 3,
  parameter int VEC_BASE   = 0,
  parameter int VEC_STRIDE = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instruction,
  output logic [WIDTH-1:0]    instr_addr,
  input  logic [CORE_NUM-1:0] core_index,
  output logic                request,
  output logic                wren,
  output logic [WIDTH-1:0]    address,
  output logic [WIDTH-1:0]    writedata,
  input  logic [WIDTH-1:0]    readdata,
  input  logic                response,
  input  logic                interrupt_start,
  input  logic [INT_NUM-1:0]  int_vector,
  output logic                interrupt_finish,
  output logic [INT_NUM-1:0]  int_num
);

  typedef enum logic [1:0] {
    IDLE, FETCH, EXEC, MEM_WAIT
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]   regs [REG_NUM];
  logic [WIDTH-1:0]   ip, ip_nx;
  logic [3:0]         flags, flags_nx;
  logic [31:0]        ir;

  logic [1:0]         cls;
  logic [2:0]         cnd, sub;
  logic [3:0]         rd, rs;
  logic [15:0]        imm;

  logic [WIDTH-1:0]   rd_val, rs_val;
  logic               cond_ok;
  logic [WIDTH:0]     sum, dif;
  logic               big_sh;
  logic [WIDTH-1:0]   alu_res;
  logic [3:0]         alu_flags;
  logic               alu_c, alu_o;

  logic               wb_en;
  logic [WIDTH-1:0]   wb_data;
  logic               req_nx, wren_nx, fin_nx;
  logic [WIDTH-1:0]   addr_nx, wdata_nx;
  logic [INT_NUM-1:0] inum_nx;
  logic [WIDTH-1:0]   vec_ip, rel_ip;

  assign cls = ir[31:30];
  assign cnd = ir[29:27];
  assign sub = ir[26:24];
  assign rd  = ir[23:20];
  assign rs  = ir[19:16];
  assign imm = ir[15:0];

  assign instr_addr = ip;

  assign vec_ip = WIDTH'(VEC_BASE)
                + WIDTH'(int_vector) * WIDTH'(VEC_STRIDE);
  assign rel_ip = ip + WIDTH'($signed(imm));

  // register file read; indices past the file read as zero
  always_comb begin
    rd_val = '0;
    rs_val = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (rd == 4'(i)) rd_val = regs[i];
      if (rs == 4'(i)) rs_val = regs[i];
    end
  end

  // condition suffix against flags {Z,O,S,C}
  always_comb begin
    unique case (cnd)
      3'b000:  cond_ok = 1'b1;
      3'b001:  cond_ok = flags[3];
      3'b010:  cond_ok = !flags[3];
      3'b011:  cond_ok = flags[0];
      3'b100:  cond_ok = flags[1] != flags[2];
      3'b101:  cond_ok = flags[1] == flags[2];
      default: cond_ok = 1'b0;
    endcase
  end

  assign sum    = {1'b0, rd_val} + {1'b0, rs_val};
  assign dif    = {1'b0, rd_val} - {1'b0, rs_val};
  assign big_sh = rs_val >= WIDTH'(WIDTH);

  // ALU result and flag generation
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (sub)
      3'b000: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_o   = (rd_val[WIDTH-1] == rs_val[WIDTH-1])
               && (alu_res[WIDTH-1] != rd_val[WIDTH-1]);
      end
      3'b001, 3'b111: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];
        alu_o   = (rd_val[WIDTH-1] != rs_val[WIDTH-1])
               && (alu_res[WIDTH-1] != rd_val[WIDTH-1]);
      end
      3'b010:  alu_res = rd_val & rs_val;
      3'b011:  alu_res = rd_val | rs_val;
      3'b100:  alu_res = rd_val ^ rs_val;
      3'b101:  alu_res = big_sh ? '0 : rd_val << rs_val;
      default: alu_res = big_sh ? '0 : rd_val >> rs_val;
    endcase
    alu_flags = {alu_res == '0, alu_o, alu_res[WIDTH-1], alu_c};
  end

  // sequencer state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next state and datapath updates
  always_comb begin
    state_nx = state;
    ip_nx    = ip;
    flags_nx = flags;
    wb_en    = 1'b0;
    wb_data  = rd_val;
    req_nx   = request;
    wren_nx  = wren;
    addr_nx  = address;
    wdata_nx = writedata;
    fin_nx   = 1'b0;
    inum_nx  = int_num;
    unique case (state)
      IDLE: begin
        if (interrupt_start) begin
          ip_nx    = vec_ip;
          state_nx = FETCH;
        end
      end
      FETCH: state_nx = EXEC;
      EXEC: begin
        state_nx = FETCH;
        ip_nx    = ip + WIDTH'(1);
        if (cond_ok) begin
          unique case (cls)
            2'b00: begin
              wb_en    = sub != 3'b111;
              wb_data  = alu_res;
              flags_nx = alu_flags;
            end
            2'b01: begin
              wb_en = 1'b1;
              case (sub)
                3'b000:  wb_data = rs_val;
                3'b001:  wb_data[15:0] = imm;
                3'b010:  wb_data[WIDTH-1 -: 16] = imm;
                3'b011:  wb_data = WIDTH'(flags);
                3'b100:  wb_data = WIDTH'(core_index);
                default: wb_en = 1'b0;
              endcase
            end
            2'b10: begin
              if (sub[2:1] == 2'b00) begin
                req_nx   = 1'b1;
                wren_nx  = sub[0];
                addr_nx  = rs_val;
                wdata_nx = rd_val;
                ip_nx    = ip;
                state_nx = MEM_WAIT;
              end
            end
            2'b11: begin
              case (sub)
                3'b000: ip_nx = rs_val;
                3'b001: ip_nx = rel_ip;
                3'b111: begin
                  ip_nx    = ip;
                  fin_nx   = 1'b1;
                  inum_nx  = imm[INT_NUM-1:0];
                  state_nx = IDLE;
                end
                default: ;
              endcase
            end
          endcase
        end
      end
      MEM_WAIT: begin
        if (response) begin
          req_nx   = 1'b0;
          ip_nx    = ip + WIDTH'(1);
          state_nx = FETCH;
          if (!wren) begin
            wb_en   = 1'b1;
            wb_data = readdata;
          end
        end
      end
    endcase
  end

  // architectural and bus registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ip               <= '0;
      flags            <= '0;
      ir               <= '0;
      request          <= 1'b0;
      wren             <= 1'b0;
      address          <= '0;
      writedata        <= '0;
      interrupt_finish <= 1'b0;
      int_num          <= '0;
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      ip               <= ip_nx;
      flags            <= flags_nx;
      request          <= req_nx;
      wren             <= wren_nx;
      address          <= addr_nx;
      writedata        <= wdata_nx;
      interrupt_finish <= fin_nx;
      int_num          <= inum_nx;
      if (state == FETCH) ir <= instruction;
      for (int i = 0; i < REG_NUM; i++) begin
        if (wb_en && rd == 4'(i)) regs[i] <= wb_data;
      end
    end
  end

endmodule
